// File: rtl/ex_mem_pipe_stage_if.sv
// rtl/ex_mem_pipe_stage_if.sv - EX->MEM handshake and field bus for the EX/MEM pipeline register
interface ex_mem_pipe_stage_if #(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int WBW  = 2,
   parameter int CNTW = 16
);
   // EX side
   logic            in_valid;
   logic            in_ready;
   logic [WBW-1:0]  in_wb_ctl;
   logic [2:0]      in_m_ctl;
   logic [XLEN-1:0] in_add_result;
   logic            in_zero;
   logic [XLEN-1:0] in_alu_result;
   logic [XLEN-1:0] in_rdata2;
   logic [REGW-1:0] in_dest;

   // MEM side
   logic            out_valid;
   logic            out_ready;
   logic [WBW-1:0]  wb_ctlout;
   logic            branch;
   logic            memread;
   logic            memwrite;
   logic [XLEN-1:0] add_result;
   logic            zero;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] rdata2out;
   logic [REGW-1:0] five_bit_muxout;
   logic            take_branch;

   // status
   logic [1:0]      occupancy;
   logic [CNTW-1:0] stall_cnt;

   modport master (
      output in_valid, in_wb_ctl, in_m_ctl, in_add_result, in_zero, in_alu_result,
             in_rdata2, in_dest, out_ready,
      input  in_ready, out_valid, wb_ctlout, branch, memread, memwrite, add_result, zero,
             alu_result, rdata2out, five_bit_muxout, take_branch, occupancy, stall_cnt
   );

   modport slave (
      input  in_valid, in_wb_ctl, in_m_ctl, in_add_result, in_zero, in_alu_result,
             in_rdata2, in_dest, out_ready,
      output in_ready, out_valid, wb_ctlout, branch, memread, memwrite, add_result, zero,
             alu_result, rdata2out, five_bit_muxout, take_branch, occupancy, stall_cnt
   );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// rtl/ex_mem_pipe_stage.sv - elastic EX/MEM pipeline register with 2-entry skid buffer
module ex_mem_pipe_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int WBW  = 2,
   parameter int CNTW = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   ex_mem_pipe_stage_if.slave bus
);
   // entry layout, MSB first: wb_ctl, m_ctl{branch,memread,memwrite}, add_result, zero,
   // alu_result, rdata2, dest; control bits sit on top so they can be zeroed as one slice
   localparam int CW = WBW + 3;
   localparam int EW = CW + XLEN + 1 + XLEN + XLEN + REGW;
   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

   logic            head_valid_q, head_valid_d;
   logic            skid_valid_q, skid_valid_d;
   logic [EW-1:0]   head_q, head_d;
   logic [EW-1:0]   skid_q, skid_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
   logic [EW-1:0]   in_beat;
   logic            push;
   logic            pop;

   assign in_beat = {bus.in_wb_ctl, bus.in_m_ctl, bus.in_add_result, bus.in_zero,
                     bus.in_alu_result, bus.in_rdata2, bus.in_dest};
   assign push    = bus.in_valid & ~skid_valid_q;
   assign pop     = head_valid_q & bus.out_ready;

   // slot next-state: head refills from skid first, then from EX; skid only catches a beat
   // that arrives while the head is stalled
   always_comb begin
      head_valid_d = head_valid_q;
      skid_valid_d = skid_valid_q;
      head_d       = head_q;
      skid_d       = skid_q;
      if (flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!head_valid_q) begin
         if (push) begin
            head_valid_d = 1'b1;
            head_d       = in_beat;
         end
      end else if (pop) begin
         if (skid_valid_q) begin
            head_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (push) begin
            head_d = in_beat;
         end else begin
            head_valid_d = 1'b0;
         end
      end else if (push) begin
         skid_valid_d = 1'b1;
         skid_d       = in_beat;
      end
      // a bubble must never carry live control into MEM; data fields keep their last value
      if (!head_valid_d) begin
         head_d[EW-1 -: CW] = '0;
      end
   end

   // stall counter: counts cycles MEM refuses a valid head, sticks at all-ones
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (head_valid_q && !bus.out_ready && stall_cnt_q != CNT_MAX) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   // state registers; only rst clears the stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         head_q       <= '0;
         skid_q       <= '0;
         stall_cnt_q  <= '0;
      end else begin
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
         head_q       <= head_d;
         skid_q       <= skid_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bus.in_ready  = ~skid_valid_q;
   assign bus.out_valid = head_valid_q;
   assign {bus.wb_ctlout, bus.branch, bus.memread, bus.memwrite, bus.add_result, bus.zero,
           bus.alu_result, bus.rdata2out, bus.five_bit_muxout} = head_q;
   assign bus.take_branch = head_valid_q & bus.branch & bus.zero;
   assign bus.occupancy   = {head_valid_q & skid_valid_q, head_valid_q ^ skid_valid_q};
   assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// tb/tb_ex_mem_pipe_stage.sv - self-checking bench for ex_mem_pipe_stage
module tb_ex_mem_pipe_stage;
   localparam int XLEN = 32;
   localparam int REGW = 5;
   localparam int WBW  = 2;
   localparam int CNTW = 4;
   localparam int SAT  = (1 << CNTW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   ex_mem_pipe_stage_if #(.XLEN(XLEN), .REGW(REGW), .WBW(WBW), .CNTW(CNTW)) bus ();

   ex_mem_pipe_stage #(.XLEN(XLEN), .REGW(REGW), .WBW(WBW), .CNTW(CNTW)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [31:0] add;
      logic        zero;
      logic [31:0] alu;
      logic [31:0] rd2;
      logic [4:0]  dest;
   } beat_t;

   beat_t       mq[$];
   beat_t       last_b;
   beat_t       m_in;
   beat_t       h;
   int          m_sz;
   int          m_cnt;
   logic [4:0]  exp_ctl;
   int          errors = 0;
   int          checks = 0;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: FIFO of at most two beats, head visible to MEM
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         last_b = '0;
         m_cnt  = 0;
      end else begin
         m_sz = mq.size();
         if (m_sz > 0 && !bus.out_ready && m_cnt < SAT) m_cnt++;
         if (flush) begin
            mq.delete();
         end else begin
            if (m_sz > 0 && bus.out_ready) void'(mq.pop_front());
            if (bus.in_valid && m_sz < 2) begin
               m_in = {bus.in_wb_ctl, bus.in_m_ctl, bus.in_add_result, bus.in_zero,
                       bus.in_alu_result, bus.in_rdata2, bus.in_dest};
               mq.push_back(m_in);
            end
            if (mq.size() > 0) last_b = mq[0];
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         h       = (mq.size() > 0) ? mq[0] : last_b;
         exp_ctl = (mq.size() > 0) ? {h.wb, h.m} : 5'b0;
         check("handshake", {bus.out_valid, bus.in_ready, bus.occupancy},
               {mq.size() > 0, mq.size() < 2, 2'(mq.size())});
         check("ctl", {bus.wb_ctlout, bus.branch, bus.memread, bus.memwrite}, exp_ctl);
         check("data", {bus.add_result, bus.zero, bus.alu_result, bus.rdata2out, bus.five_bit_muxout},
               {h.add, h.zero, h.alu, h.rd2, h.dest});
         check("take_branch", bus.take_branch, mq.size() > 0 && h.m[2] && h.zero);
         check("stall_cnt", bus.stall_cnt, m_cnt);
      end
   end

   task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] add,
                        input logic z, input logic [31:0] alu, input logic [31:0] rd2,
                        input logic [4:0] d);
      bus.in_valid      = 1'b1;
      bus.in_wb_ctl     = wb;
      bus.in_m_ctl      = m;
      bus.in_add_result = add;
      bus.in_zero       = z;
      bus.in_alu_result = alu;
      bus.in_rdata2     = rd2;
      bus.in_dest       = d;
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bus.in_valid      = 1'b0;
      bus.in_wb_ctl     = '0;
      bus.in_m_ctl      = '0;
      bus.in_add_result = '0;
      bus.in_zero       = 1'b0;
      bus.in_alu_result = '0;
      bus.in_rdata2     = '0;
      bus.in_dest       = '0;
      bus.out_ready     = 1'b1;
      tick(2);
      rst    = 1'b0;
      chk_en = 1'b1;
      check("rst_occ", bus.occupancy, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);

      // streaming, latency 1
      for (int i = 1; i <= 4; i++) begin
         drive(2'b10, 3'b000, 32'h0, 1'b0, i, 32'h100 + i, 5'(i));
         tick();
         check("t1_alu", bus.alu_result, i);
      end
      bus.in_valid = 1'b0;
      tick();
      check("t1_drain", bus.out_valid, 0);
      check("t1_stall", bus.stall_cnt, 0);

      // backpressure into skid
      drive(2'b01, 3'b010, 32'h0, 1'b0, 32'hA, 32'h0, 5'd10);
      tick();
      bus.out_ready = 1'b0;
      drive(2'b01, 3'b010, 32'h0, 1'b0, 32'hB, 32'h0, 5'd11);
      tick();
      check("t2_in_ready", bus.in_ready, 0);
      check("t2_occ2", bus.occupancy, 2);
      drive(2'b01, 3'b010, 32'h0, 1'b0, 32'hC, 32'h0, 5'd12);
      tick(3);
      check("t2_stall", bus.stall_cnt, 4);
      check("t2_A", bus.alu_result, 32'hA);
      bus.out_ready = 1'b1;
      tick();
      check("t2_B", bus.alu_result, 32'hB);
      check("t2_occB", bus.occupancy, 1);
      tick();
      check("t2_C", bus.alu_result, 32'hC);
      check("t2_occC", bus.occupancy, 1);
      bus.in_valid = 1'b0;
      tick();
      check("t2_occ0", bus.occupancy, 0);

      // flush with two held entries and a beat presented
      bus.out_ready = 1'b0;
      drive(2'b11, 3'b001, 32'h0, 1'b0, 32'hE, 32'h0, 5'd14);
      tick();
      drive(2'b11, 3'b001, 32'h0, 1'b0, 32'hF, 32'h0, 5'd15);
      tick();
      check("t3_occ2", bus.occupancy, 2);
      flush = 1'b1;
      drive(2'b11, 3'b001, 32'h0, 1'b0, 32'hD, 32'h0, 5'd13);
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      check("t3_out_valid", bus.out_valid, 0);
      check("t3_memwrite", bus.memwrite, 0);
      check("t3_wb", bus.wb_ctlout, 0);
      check("t3_in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      tick(2);
      check("t3_no_D", bus.out_valid, 0);

      // branch decision
      drive(2'b00, 3'b100, 32'h40, 1'b1, 32'h5, 32'h0, 5'd0);
      tick();
      bus.in_valid = 1'b0;
      check("t4_take", bus.take_branch, 1);
      check("t4_target", bus.add_result, 32'h40);
      tick();
      check("t4_take_gone", bus.take_branch, 0);
      drive(2'b00, 3'b100, 32'h80, 1'b0, 32'h6, 32'h0, 5'd0);
      tick();
      bus.in_valid = 1'b0;
      check("t4_nottaken", bus.take_branch, 0);
      check("t4_branch", bus.branch, 1);
      tick();

      // stall counter saturation
      bus.out_ready = 1'b0;
      drive(2'b01, 3'b000, 32'h0, 1'b0, 32'h77, 32'h0, 5'd7);
      tick();
      bus.in_valid = 1'b0;
      tick(20);
      check("t5_sat", bus.stall_cnt, SAT);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t5_flush_keeps", bus.stall_cnt, SAT);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_rst_clears", bus.stall_cnt, 0);

      // reset with two held entries
      drive(2'b10, 3'b011, 32'h123, 1'b1, 32'h88, 32'h99, 5'd8);
      tick();
      drive(2'b10, 3'b011, 32'h456, 1'b1, 32'h89, 32'h9A, 5'd9);
      tick();
      check("t6_occ2", bus.occupancy, 2);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      rst = 1'b0;
      check("t6_occ", bus.occupancy, 0);
      check("t6_out_valid", bus.out_valid, 0);
      check("t6_in_ready", bus.in_ready, 1);
      check("t6_alu", bus.alu_result, 0);
      check("t6_wb", bus.wb_ctlout, 0);
      check("t6_stall", bus.stall_cnt, 0);
      bus.out_ready = 1'b1;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
